// File: rtl/rv32_alu_dec_pkg.sv
// Shared types and encodings for the rv32_alu decode/issue stage: register and ALU-op types,
// RV32I major opcodes, funct3/funct7 values and the decoder FSM state type.
package rv32_alu_dec_pkg;

    typedef logic [31:0] rv_register_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11
    } rv_alu_op_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StIssue = 2'd2
    } rv_dec_state_t;

    // Shared by OP and OP-IMM; 'alt' is funct7[5], selecting SUB/SRA.
    function automatic rv_alu_op_t arith_op(input logic [2:0] f3, input logic alt);
        rv_alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational I/B/U immediate extraction with sign extension for the decode stage.
module rv32_imm_gen
    import rv32_alu_dec_pkg::*;
(
    input  logic [31:0]  instr,
    output rv_register_t imm_i,
    output rv_register_t imm_b,
    output rv_register_t imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    logic unused_opc;
    assign unused_opc = ^instr[6:0];

endmodule

// File: rtl/rv32_alu_dec.sv
// RV32I decode/issue stage in front of rv32_alu: OP, OP-IMM, BRANCH and LUI, all else illegal.
// Optional writeback bypass into the operands is enabled by defining RV32_ALU_DEC_BYPASS_EN.
module rv32_alu_dec
    import rv32_alu_dec_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,

    output logic [RF_AW-1:0] rf_rs1_addr,
    output logic [RF_AW-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,

    input  logic             wb_valid,
    input  logic [RF_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    output logic             out_valid,
    input  logic             out_ready,
    output rv_register_t     alu_rs1,
    output rv_register_t     alu_rs2,
    output rv_alu_op_t       alu_opcode,
    output logic [XLEN-1:0]  imm,
    output logic [RF_AW-1:0] rd,
    output logic             wb_en,
    output logic             is_branch,
    output logic             cmp_inv,
    output logic             illegal
);

    rv_dec_state_t    state_q, state_d;
    logic [31:0]      instr_q;
    logic             capture;
    logic             load;

    rv_register_t     alu_rs1_q;
    rv_register_t     alu_rs2_q;
    rv_alu_op_t       alu_opcode_q;
    logic [XLEN-1:0]  imm_q;
    logic [RF_AW-1:0] rd_q;
    logic             wb_en_q;
    logic             is_branch_q;
    logic             cmp_inv_q;
    logic             illegal_q;

    // The regfile samples these on the accept edge, so they follow the incoming word.
    assign rf_rs1_addr = instr[19:15];
    assign rf_rs2_addr = instr[24:20];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        load        = 1'b0;
        instr_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    capture = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                load    = 1'b1;
                state_d = StIssue;
            end
            StIssue: begin
                instr_ready = out_ready;
                if (out_ready) begin
                    if (instr_valid) begin
                        capture = 1'b1;
                        state_d = StRead;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            instr_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q <= instr;
            end
        end
    end

    assign out_valid = (state_q == StIssue);

    // ------------------------------------------------------------------
    // Field extraction and immediates
    // ------------------------------------------------------------------
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [RF_AW-1:0] rs1_idx;
    logic [RF_AW-1:0] rs2_idx;
    logic [RF_AW-1:0] rd_idx;
    rv_register_t     imm_i;
    rv_register_t     imm_b;
    rv_register_t     imm_u;
    rv_register_t     shamt;

    assign opc     = instr_q[6:0];
    assign rd_idx  = instr_q[11:7];
    assign f3      = instr_q[14:12];
    assign rs1_idx = instr_q[19:15];
    assign rs2_idx = instr_q[24:20];
    assign f7      = instr_q[31:25];
    assign shamt   = {27'b0, instr_q[24:20]};

    rv32_imm_gen u_imm_gen (
        .instr (instr_q),
        .imm_i (imm_i),
        .imm_b (imm_b),
        .imm_u (imm_u)
    );

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    rv_register_t rs1_val;
    rv_register_t rs2_val;

    always_comb begin
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
`ifdef RV32_ALU_DEC_BYPASS_EN
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs1_idx)) begin
            rs1_val = wb_data;
        end
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs2_idx)) begin
            rs2_val = wb_data;
        end
`endif
        if (rs1_idx == '0) begin
            rs1_val = '0;
        end
        if (rs2_idx == '0) begin
            rs2_val = '0;
        end
    end

`ifndef RV32_ALU_DEC_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    rv_alu_op_t   dec_op;
    rv_register_t dec_src1;
    rv_register_t dec_src2;
    rv_register_t dec_imm;
    logic         dec_illegal;
    logic         dec_branch;
    logic         dec_inv;
    logic         dec_wb_en;
    logic         is_shift;

    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SR);

    always_comb begin
        dec_op      = ALU_ADD;
        dec_src1    = rs1_val;
        dec_src2    = rs2_val;
        dec_imm     = '0;
        dec_illegal = 1'b1;
        dec_branch  = 1'b0;
        dec_inv     = 1'b0;
        case (opc)
            OPC_OP: begin
                if ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)))) begin
                    dec_illegal = 1'b0;
                    dec_op      = arith_op(f3, f7[5]);
                end
            end
            OPC_OP_IMM: begin
                dec_imm  = imm_i;
                dec_src2 = imm_i;
                if (!is_shift) begin
                    // Upper immediate bits are data here, so there is no SUBI.
                    dec_illegal = 1'b0;
                    dec_op      = arith_op(f3, 1'b0);
                end else begin
                    dec_src2 = shamt;
                    if ((f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_SR))) begin
                        dec_illegal = 1'b0;
                        dec_op      = arith_op(f3, f7[5]);
                    end
                end
            end
            OPC_BRANCH: begin
                dec_imm     = imm_b;
                dec_illegal = 1'b0;
                dec_branch  = 1'b1;
                case (f3)
                    F3_BEQ:  dec_op = ALU_EQ;
                    F3_BNE:  dec_op = ALU_NE;
                    F3_BLT:  dec_op = ALU_SLT;
                    F3_BGE: begin
                        dec_op  = ALU_SLT;
                        dec_inv = 1'b1;
                    end
                    F3_BLTU: dec_op = ALU_SLTU;
                    F3_BGEU: begin
                        dec_op  = ALU_SLTU;
                        dec_inv = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_illegal = 1'b0;
                dec_src1    = '0;
                dec_src2    = imm_u;
                dec_imm     = imm_u;
            end
            default: ;
        endcase

        // Illegal ops still travel down the pipe, but as an inert ADD.
        if (dec_illegal) begin
            dec_op     = ALU_ADD;
            dec_imm    = '0;
            dec_branch = 1'b0;
            dec_inv    = 1'b0;
        end
        dec_wb_en = !dec_illegal && !dec_branch && (rd_idx != '0);
    end

    // ------------------------------------------------------------------
    // Issue registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_rs1_q    <= '0;
            alu_rs2_q    <= '0;
            alu_opcode_q <= ALU_ADD;
            imm_q        <= '0;
            rd_q         <= '0;
            wb_en_q      <= 1'b0;
            is_branch_q  <= 1'b0;
            cmp_inv_q    <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (load) begin
            alu_rs1_q    <= dec_src1;
            alu_rs2_q    <= dec_src2;
            alu_opcode_q <= dec_op;
            imm_q        <= dec_imm;
            rd_q         <= rd_idx;
            wb_en_q      <= dec_wb_en;
            is_branch_q  <= dec_branch;
            cmp_inv_q    <= dec_inv;
            illegal_q    <= dec_illegal;
        end
    end

    assign alu_rs1    = alu_rs1_q;
    assign alu_rs2    = alu_rs2_q;
    assign alu_opcode = alu_opcode_q;
    assign imm        = imm_q;
    assign rd         = rd_q;
    assign wb_en      = wb_en_q;
    assign is_branch  = is_branch_q;
    assign cmp_inv    = cmp_inv_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_rv32_alu_dec.sv
// Self-checking bench for rv32_alu_dec: directed vector table, handshake/reset sequences and
// randomized instructions against a table-based decode model.
module tb_rv32_alu_dec;
    import rv32_alu_dec_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [4:0]   rf_rs1_addr;
    logic [4:0]   rf_rs2_addr;
    logic [31:0]  rf_rs1_data;
    logic [31:0]  rf_rs2_data;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         out_valid;
    logic         out_ready;
    rv_register_t alu_rs1;
    rv_register_t alu_rs2;
    rv_alu_op_t   alu_opcode;
    logic [31:0]  imm;
    logic [4:0]   rd;
    logic         wb_en;
    logic         is_branch;
    logic         cmp_inv;
    logic         illegal;

    always #5 clk = ~clk;

    rv32_alu_dec dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_rs1_addr (rf_rs1_addr),
        .rf_rs2_addr (rf_rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_opcode  (alu_opcode),
        .imm         (imm),
        .rd          (rd),
        .wb_en       (wb_en),
        .is_branch   (is_branch),
        .cmp_inv     (cmp_inv),
        .illegal     (illegal)
    );

    // Synchronous-read register file model
    logic [31:0] rf [32];
    always @(posedge clk) begin
        rf_rs1_data <= rf[rf_rs1_addr];
        rf_rs2_data <= rf[rf_rs2_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        rv_alu_op_t  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wb_en;
        logic        br;
        logic        inv;
        logic        ill;
        logic        chk_imm;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        exp_t        e;
    } vec_t;

    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        rv_alu_op_t  base_tab [8];
        rv_alu_op_t  br_tab [8];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] ii;
        logic [31:0] ib;
        logic [31:0] iu;
        base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        br_tab   = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        v1  = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
        v2  = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'h000};
        e = '{ALU_ADD, v1, v2, 32'd0, ins[11:7], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                e.ill = 1'b0;
                e.op  = base_tab[f3];
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                e.ill = 1'b0;
                e.op  = ALU_SUB;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                e.ill = 1'b0;
                e.op  = ALU_SRA;
            end
        end else if (opc == 7'h13) begin
            e.imm = ii;
            if (f3 != 3'd1 && f3 != 3'd5) begin
                e.ill = 1'b0;
                e.op  = base_tab[f3];
                e.rs2 = ii;
            end else if (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) begin
                e.ill = 1'b0;
                e.op  = (f7 == 7'h20) ? ALU_SRA : base_tab[f3];
                e.rs2 = 32'(ins[24:20]);
            end
        end else if (opc == 7'h63) begin
            if (f3 != 3'd2 && f3 != 3'd3) begin
                e.ill = 1'b0;
                e.br  = 1'b1;
                e.op  = br_tab[f3];
                e.inv = (f3 == 3'd5) || (f3 == 3'd7);
                e.imm = ib;
            end
        end else if (opc == 7'h37) begin
            e.ill = 1'b0;
            e.rs1 = 32'd0;
            e.rs2 = iu;
            e.imm = iu;
        end
        if (e.ill) e.imm = 32'd0;
        e.wb_en   = !e.ill && !e.br && (ins[11:7] != 5'd0);
        e.chk_imm = !e.ill && (opc != 7'h33);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0, 1: begin
                r[6:0] = (k == 0) ? 7'h33 : 7'h13;
                case ($urandom_range(0, 2))
                    0:       r[31:25] = 7'h00;
                    1:       r[31:25] = 7'h20;
                    default: ;
                endcase
            end
            2: r[6:0] = 7'h63;
            3: r[6:0] = 7'h37;
            4: begin
                r[6:0]   = 7'h33;
                r[31:25] = 7'h00;
                r[19:15] = 5'd0;
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, " op"}, 32'(alu_opcode), 32'(e.op));
        chk({tag, " wb_en"}, 32'(wb_en), 32'(e.wb_en));
        chk({tag, " is_branch"}, 32'(is_branch), 32'(e.br));
        chk({tag, " cmp_inv"}, 32'(cmp_inv), 32'(e.inv));
        chk({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        if (!e.ill) begin
            chk({tag, " alu_rs1"}, alu_rs1, e.rs1);
            chk({tag, " alu_rs2"}, alu_rs2, e.rs2);
        end
        if (e.chk_imm) chk({tag, " imm"}, imm, e.imm);
        if (!e.ill && !e.br) chk({tag, " rd"}, 32'(rd), 32'(e.rd));
    endtask

    // Called #1 after a rising edge with the DUT idle; leaves it idle again.
    task automatic run_one(input logic [31:0] ins, input exp_t e, input string tag,
                           input int stall);
        instr       = ins;
        instr_valid = 1'b1;
        out_ready   = 1'b0;
        chk({tag, " idle ready"}, 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        chk({tag, " valid in read"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, " stall ready"}, 32'(instr_ready), 32'd0);
        end
        chk({tag, " held valid"}, 32'(out_valid), 32'd1);
        check_out(tag, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;

    vec_t tab [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        out_ready   = 1'b0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        for (int j = 0; j < 32; j++) rf[j] = $urandom;
        rf[0] = 32'hDEADBEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        tab[0] = '{I_ADD,        '{ALU_ADD, 5, 7, 0, 3, 1, 0, 0, 0, 0}};
        tab[1] = '{I_SUB,        '{ALU_SUB, 5, 7, 0, 3, 1, 0, 0, 0, 0}};
        tab[2] = '{32'hFFF00293, '{ALU_ADD, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1, 0, 0, 0, 1}};
        tab[3] = '{32'h0020D463, '{ALU_SLT, 5, 7, 8, 8, 0, 1, 1, 0, 1}};
        tab[4] = '{32'h0020A463, '{ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0}};
        tab[5] = '{32'h123453B7, '{ALU_ADD, 0, 32'h12345000, 32'h12345000, 7, 1, 0, 0, 0, 1}};
        tab[6] = '{32'h00000000, '{ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0}};
        tab[7] = '{32'h4030D213, '{ALU_SRA, 5, 3, 32'h403, 4, 1, 0, 0, 0, 1}};
        tab[8] = '{32'h40109213, '{ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0}};
        tab[9] = '{32'h022081B3, '{ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset instr_ready", 32'(instr_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset alu_rs1", alu_rs1, 32'd0);
        chk("reset alu_rs2", alu_rs2, 32'd0);
        chk("reset imm", imm, 32'd0);
        chk("reset flags", 32'({wb_en, is_branch, cmp_inv, illegal, rd}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset instr_ready", 32'(instr_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_one(tab[i].ins, tab[i].e, $sformatf("vec%0d", i), 1);
        end

        // Back-to-back ADD then SUB, then backpressure on SUB
        instr       = I_ADD;
        instr_valid = 1'b1;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        instr = I_SUB;
        chk("b2b ready in read", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        chk("b2b add valid", 32'(out_valid), 32'd1);
        chk("b2b add op", 32'(alu_opcode), 32'(ALU_ADD));
        chk("b2b issue ready", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        chk("b2b gap", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("b2b sub valid", 32'(out_valid), 32'd1);
        chk("b2b sub op", 32'(alu_opcode), 32'(ALU_SUB));
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("hold valid", 32'(out_valid), 32'd1);
            chk("hold op", 32'(alu_opcode), 32'(ALU_SUB));
            chk("hold rs1", alu_rs1, 32'd5);
            chk("hold rs2", alu_rs2, 32'd7);
            chk("hold instr_ready", 32'(instr_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b drained", 32'(out_valid), 32'd0);
        chk("b2b idle", 32'(instr_ready), 32'd1);

        // Reset while in READ
        instr       = I_ADD;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst         = 1'b1;
        #1;
        chk("rst-read instr_ready", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-read out_valid", 32'(out_valid), 32'd0);
        chk("rst-read alu_rs1", alu_rs1, 32'd0);
        chk("rst-read wb_en", 32'(wb_en), 32'd0);
        @(posedge clk); #1;
        chk("rst-read stays idle", 32'(out_valid), 32'd0);
        chk("rst-read idle ready", 32'(instr_ready), 32'd1);

        // Writeback bypass during READ
        instr       = I_ADD;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wb_valid    = 1'b1;
        wb_rd       = 5'd1;
        wb_data     = 32'h55;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("bypass valid", 32'(out_valid), 32'd1);
`ifdef RV32_ALU_DEC_BYPASS_EN
        chk("bypass rs1", alu_rs1, 32'h55);
`else
        chk("bypass rs1", alu_rs1, 32'd5);
`endif
        chk("bypass rs2", alu_rs2, 32'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized instructions and register contents
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins;
            exp_t        e;
            for (int j = 0; j < 32; j++) rf[j] = $urandom;
            ins = rand_instr();
            e   = model(ins);
            run_one(ins, e, $sformatf("rnd%0d(%h)", n, ins), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
